// File: rtl/naive_bus_rom_arbiter.sv
// Two-master round-robin arbiter onto one naive_bus slave with registered read data.
// Holds the selection across slave stalls and routes each read return to its issuer.
module naive_bus_rom_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // master 0: instruction fetch
  input  logic              m0_rd_req,
  input  logic [ADDR_W-1:0] m0_rd_addr,
  output logic              m0_rd_gnt,
  output logic [DATA_W-1:0] m0_rd_data,
  input  logic              m0_wr_req,
  input  logic [ADDR_W-1:0] m0_wr_addr,
  input  logic [DATA_W-1:0] m0_wr_data,
  output logic              m0_wr_gnt,
  // master 1: debug / loader
  input  logic              m1_rd_req,
  input  logic [ADDR_W-1:0] m1_rd_addr,
  output logic              m1_rd_gnt,
  output logic [DATA_W-1:0] m1_rd_data,
  input  logic              m1_wr_req,
  input  logic [ADDR_W-1:0] m1_wr_addr,
  input  logic [DATA_W-1:0] m1_wr_data,
  output logic              m1_wr_gnt,
  // slave
  output logic              s_rd_req,
  output logic [ADDR_W-1:0] s_rd_addr,
  input  logic              s_rd_gnt,
  input  logic [DATA_W-1:0] s_rd_data,
  output logic              s_wr_req,
  output logic [ADDR_W-1:0] s_wr_addr,
  output logic [DATA_W-1:0] s_wr_data,
  input  logic              s_wr_gnt
);

  typedef enum logic [0:0] {StFree, StHold} state_e;

  state_e state_q, state_d;
  logic   sel_q, sel_d;
  logic   prio_q, prio_d;
  logic   rd_pend_q, rd_pend_d;
  logic   rd_owner_q, rd_owner_d;

  logic              m0_req, m1_req;
  logic              cur_sel;
  logic              sel_rd_req, sel_wr_req;
  logic              cur_rd, cur_wr;
  logic              rd_fire, wr_fire;
  logic [ADDR_W-1:0] sel_rd_addr, sel_wr_addr;
  logic [DATA_W-1:0] sel_wr_data;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StFree;
      sel_q      <= 1'b0;
      prio_q     <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      prio_q     <= prio_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // Master selection and request muxing; a master's read beats its own write
  always_comb begin
    m0_req = m0_rd_req | m0_wr_req;
    m1_req = m1_rd_req | m1_wr_req;
    if (state_q == StHold) begin
      cur_sel = sel_q;
    end else if (m0_req && m1_req) begin
      cur_sel = prio_q;
    end else begin
      cur_sel = m1_req;
    end
    sel_rd_req  = cur_sel ? m1_rd_req  : m0_rd_req;
    sel_wr_req  = cur_sel ? m1_wr_req  : m0_wr_req;
    sel_rd_addr = cur_sel ? m1_rd_addr : m0_rd_addr;
    sel_wr_addr = cur_sel ? m1_wr_addr : m0_wr_addr;
    sel_wr_data = cur_sel ? m1_wr_data : m0_wr_data;
    cur_rd      = sel_rd_req;
    cur_wr      = sel_wr_req & ~sel_rd_req;
    rd_fire     = cur_rd & s_rd_gnt;
    wr_fire     = cur_wr & s_wr_gnt;
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    prio_d     = prio_q;
    rd_pend_d  = rd_fire;
    rd_owner_d = rd_fire ? cur_sel : rd_owner_q;
    if (rd_fire || wr_fire) begin
      state_d = StFree;
      prio_d  = ~cur_sel;
    end else if (cur_rd || cur_wr) begin
      // stall: keep the slave for this master until it is granted
      state_d = StHold;
      sel_d   = cur_sel;
    end else begin
      // idle, or held master withdrew its request
      state_d = StFree;
    end
  end

  // Outputs
  always_comb begin
    s_rd_req   = cur_rd;
    s_wr_req   = cur_wr;
    s_rd_addr  = cur_rd ? sel_rd_addr : '0;
    s_wr_addr  = cur_wr ? sel_wr_addr : '0;
    s_wr_data  = cur_wr ? sel_wr_data : '0;
    m0_rd_gnt  = rd_fire & ~cur_sel;
    m1_rd_gnt  = rd_fire &  cur_sel;
    m0_wr_gnt  = wr_fire & ~cur_sel;
    m1_wr_gnt  = wr_fire &  cur_sel;
    m0_rd_data = (rd_pend_q && !rd_owner_q) ? s_rd_data : '0;
    m1_rd_data = (rd_pend_q &&  rd_owner_q) ? s_rd_data : '0;
  end

endmodule

// File: tb/tb_naive_bus_rom_arbiter.sv
// Directed bench for naive_bus_rom_arbiter with a simple registered ROM slave model.
module tb_naive_bus_rom_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              m0_rd_req = 1'b0, m1_rd_req = 1'b0;
  logic              m0_wr_req = 1'b0, m1_wr_req = 1'b0;
  logic [ADDR_W-1:0] m0_rd_addr = '0, m1_rd_addr = '0;
  logic [ADDR_W-1:0] m0_wr_addr = '0, m1_wr_addr = '0;
  logic [DATA_W-1:0] m0_wr_data = '0, m1_wr_data = '0;
  logic              m0_rd_gnt, m1_rd_gnt, m0_wr_gnt, m1_wr_gnt;
  logic [DATA_W-1:0] m0_rd_data, m1_rd_data;
  logic              s_rd_req, s_wr_req;
  logic [ADDR_W-1:0] s_rd_addr, s_wr_addr;
  logic [DATA_W-1:0] s_wr_data;
  logic              s_rd_gnt = 1'b1, s_wr_gnt = 1'b1;
  logic [DATA_W-1:0] s_rd_data = '0;

  int n_cmp = 0;
  int n_err = 0;

  naive_bus_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .m0_rd_req  (m0_rd_req),
    .m0_rd_addr (m0_rd_addr),
    .m0_rd_gnt  (m0_rd_gnt),
    .m0_rd_data (m0_rd_data),
    .m0_wr_req  (m0_wr_req),
    .m0_wr_addr (m0_wr_addr),
    .m0_wr_data (m0_wr_data),
    .m0_wr_gnt  (m0_wr_gnt),
    .m1_rd_req  (m1_rd_req),
    .m1_rd_addr (m1_rd_addr),
    .m1_rd_gnt  (m1_rd_gnt),
    .m1_rd_data (m1_rd_data),
    .m1_wr_req  (m1_wr_req),
    .m1_wr_addr (m1_wr_addr),
    .m1_wr_data (m1_wr_data),
    .m1_wr_gnt  (m1_wr_gnt),
    .s_rd_req   (s_rd_req),
    .s_rd_addr  (s_rd_addr),
    .s_rd_gnt   (s_rd_gnt),
    .s_rd_data  (s_rd_data),
    .s_wr_req   (s_wr_req),
    .s_wr_addr  (s_wr_addr),
    .s_wr_data  (s_wr_data),
    .s_wr_gnt   (s_wr_gnt)
  );

  always #5 clk = ~clk;

  // ROM slave: data = addr + 0x122F8013, so 0x8000 -> 0x12300013
  always @(posedge clk) begin
    if (s_rd_req && s_rd_gnt) s_rd_data <= s_rd_addr + 32'h122F_8013;
    else                      s_rd_data <= 32'hBAD0_BAD0;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // continuous contention expectations per cycle
  logic       exp_g0 [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [31:0] exp_d0 [5] = '{32'h0, 32'h1230_0017, 32'h0, 32'h1230_0017, 32'h0};
  logic [31:0] exp_d1 [5] = '{32'h0, 32'h0, 32'h1230_001B, 32'h0, 32'h1230_001B};

  initial begin
    // Post-reset idle
    #1;
    check_eq("reset_m0_rd_data", m0_rd_data, 0);
    check_eq("reset_m1_rd_data", m1_rd_data, 0);
    do_reset();
    next_cycle();
    @(negedge clk);
    check_eq("idle_m0_rd_gnt", m0_rd_gnt, 0);
    check_eq("idle_m1_rd_gnt", m1_rd_gnt, 0);
    check_eq("idle_wr_gnts", {m0_wr_gnt, m1_wr_gnt}, 0);
    check_eq("idle_s_reqs", {s_rd_req, s_wr_req}, 0);
    check_eq("idle_s_rd_addr", s_rd_addr, 0);
    check_eq("idle_rd_data", {m0_rd_data, m1_rd_data}, 0);

    // Single master read
    next_cycle();
    m0_rd_req = 1'b1; m0_rd_addr = 32'h8000;
    @(negedge clk);
    check_eq("single_m0_rd_gnt", m0_rd_gnt, 1);
    check_eq("single_s_rd_addr", s_rd_addr, 32'h8000);
    check_eq("single_m1_rd_gnt", m1_rd_gnt, 0);
    next_cycle();
    m0_rd_req = 1'b0;
    @(negedge clk);
    check_eq("single_m0_rd_data", m0_rd_data, 32'h1230_0013);
    check_eq("single_m1_rd_data", m1_rd_data, 0);
    next_cycle();
    @(negedge clk);
    check_eq("single_data_clears", m0_rd_data, 0);

    // Continuous contention from prio = 0
    do_reset();
    next_cycle();
    m0_rd_req = 1'b1; m0_rd_addr = 32'h8004;
    m1_rd_req = 1'b1; m1_rd_addr = 32'h8008;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) begin m0_rd_req = 1'b0; m1_rd_req = 1'b0; end
      @(negedge clk);
      if (c < 4) begin
        check_eq($sformatf("cont_m0_gnt_c%0d", c), m0_rd_gnt, exp_g0[c]);
        check_eq($sformatf("cont_m1_gnt_c%0d", c), m1_rd_gnt, !exp_g0[c]);
      end
      check_eq($sformatf("cont_m0_data_c%0d", c), m0_rd_data, exp_d0[c]);
      check_eq($sformatf("cont_m1_data_c%0d", c), m1_rd_data, exp_d1[c]);
      next_cycle();
    end

    // Stall hold: prio is 0 here; m1 alone gets selected, then stalls
    s_rd_gnt = 1'b0;
    m1_rd_req = 1'b1;
    @(negedge clk);
    check_eq("stall0_s_rd_addr", s_rd_addr, 32'h8008);
    next_cycle();
    m0_rd_req = 1'b1;
    for (int c = 1; c < 3; c++) begin
      @(negedge clk);
      check_eq($sformatf("stall%0d_s_rd_addr", c), s_rd_addr, 32'h8008);
      check_eq($sformatf("stall%0d_m0_gnt", c), m0_rd_gnt, 0);
      next_cycle();
    end
    s_rd_gnt = 1'b1;
    @(negedge clk);
    check_eq("stall_release_m1_gnt", m1_rd_gnt, 1);
    check_eq("stall_release_m0_gnt", m0_rd_gnt, 0);
    next_cycle();
    @(negedge clk);
    check_eq("stall_after_m0_gnt", m0_rd_gnt, 1);
    check_eq("stall_after_m1_data", m1_rd_data, 32'h1230_001B);
    next_cycle();
    m0_rd_req = 1'b0; m1_rd_req = 1'b0;
    @(negedge clk);
    check_eq("stall_after_m0_data", m0_rd_data, 32'h1230_0017);

    // Read/write mix from prio = 0
    do_reset();
    next_cycle();
    m0_rd_req = 1'b1; m0_rd_addr = 32'h8010;
    m0_wr_req = 1'b1; m0_wr_addr = 32'h20; m0_wr_data = 32'hAAAA_5555;
    m1_wr_req = 1'b1; m1_wr_addr = 32'h30; m1_wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    check_eq("mix0_m0_rd_gnt", m0_rd_gnt, 1);
    check_eq("mix0_wr_gnts", {m0_wr_gnt, m1_wr_gnt, s_wr_req}, 0);
    check_eq("mix0_s_rd_addr", s_rd_addr, 32'h8010);
    next_cycle();
    m0_rd_req = 1'b0;
    @(negedge clk);
    check_eq("mix1_m1_wr_gnt", m1_wr_gnt, 1);
    check_eq("mix1_m0_wr_gnt", m0_wr_gnt, 0);
    check_eq("mix1_s_wr_addr", s_wr_addr, 32'h30);
    check_eq("mix1_s_wr_data", s_wr_data, 32'hDEAD_BEEF);
    check_eq("mix1_m0_rd_data", m0_rd_data, 32'h1230_0023);
    next_cycle();
    m1_wr_req = 1'b0;
    @(negedge clk);
    check_eq("mix2_m0_wr_gnt", m0_wr_gnt, 1);
    check_eq("mix2_s_wr_addr", s_wr_addr, 32'h20);
    check_eq("mix2_s_wr_data", s_wr_data, 32'hAAAA_5555);
    check_eq("mix2_m0_rd_data", m0_rd_data, 0);
    next_cycle();
    m0_wr_req = 1'b0;
    @(negedge clk);
    check_eq("mix3_rd_data", {m0_rd_data, m1_rd_data}, 0);

    // Reset during an m1 read return (prio is 1 after m0's write)
    next_cycle();
    m1_rd_req = 1'b1; m1_rd_addr = 32'h8008;
    @(negedge clk);
    check_eq("rstret_m1_gnt", m1_rd_gnt, 1);
    next_cycle();
    m1_rd_req = 1'b0;
    check_eq("rstret_m1_data", m1_rd_data, 32'h1230_001B);
    rst = 1'b1;
    #1;
    check_eq("rstret_m1_data_async", m1_rd_data, 0);
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
    check_eq("rstret_m1_data_hold", m1_rd_data, 0);
    m0_rd_req = 1'b1; m0_rd_addr = 32'h8000;
    m1_rd_req = 1'b1;
    @(negedge clk);
    check_eq("rstret_prio0_m0_gnt", m0_rd_gnt, 1);
    check_eq("rstret_prio0_m1_gnt", m1_rd_gnt, 0);
    next_cycle();
    m0_rd_req = 1'b0; m1_rd_req = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
